sqrt_unpack: RTL and testbench
==============================

SQRT_UNPACK -- requirements
Module: sqrt_unpack

Interface
REQ-001 Parameters: none; single-precision (IEEE-754 binary32) only.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 input_a  input  32  binary32 operand.
REQ-006 input_a_stb  input  1  operand valid.
REQ-007 input_a_ack  output  1  block ready to capture operand.
REQ-008 output_m  output  24  normalised mantissa; bit 23 = 1 for non-special results.
REQ-009 output_e  output  10  signed two's-complement unbiased exponent, range -149..+127.
REQ-010 output_special  output  1  operand needs no root computation; output_special_z holds the final result.
REQ-011 output_special_z  output  32  final binary32 result for special operands.
REQ-012 output_z_stb  output  1  output bundle valid.
REQ-013 output_z_ack  input  1  downstream sqrt core accepted the bundle.

Function
REQ-014 States: GET_A, UNPACK, NORMALISE, PUT_Z; all outputs are registered.
REQ-015 GET_A: input_a_ack = 1.
REQ-016 Capture occurs on the clock edge where input_a_stb && input_a_ack; at that edge input_a is latched, input_a_ack goes 0 and the state moves to UNPACK.
REQ-017 UNPACK decodes s = a[31], E = a[30:23], F = a[22:0] in this priority order:
- E=255, F!=0: special, z = 0x7FC00000.
- E=255, F=0, s=0: special, z = 0x7F800000.
- E=255, F=0, s=1: special, z = 0x7FC00000.
- E=0, F=0: special, z = {s, 31'b0} (sign-preserving zero).
- s=1 with any other E/F: special, z = 0x7FC00000.
- E=0, F!=0 (denormal): m = {1'b0, F}, e = -126, go to NORMALISE.
- Otherwise (normal): m = {1'b1, F}, e = E - 127, go to PUT_Z.
REQ-018 For special operands: output_special = 1, output_m = 0, output_e = 0, next state PUT_Z.
REQ-019 For non-special operands: output_special = 0 and output_special_z = 0.
REQ-020 NORMALISE: on each edge, if m[23] = 0 then m <= m << 1 and e <= e - 1; if m[23] = 1 the state moves to PUT_Z and m/e are held.
REQ-021 output_z_stb is set to 1 on the edge that enters PUT_Z.
REQ-022 Latency, capture edge n to output_z_stb high:
- normal or special operand: after edge n+1.
- denormal with leading 1 at F bit p: after edge n+25-p (p=22 -> n+3; p=0 -> n+25).
REQ-023 PUT_Z: all outputs are held stable while output_z_stb = 1.
REQ-024 PUT_Z exit: on the edge where output_z_ack = 1, output_z_stb goes 0, the state moves to GET_A and input_a_ack goes 1 on the same edge.
REQ-025 input_a_stb is ignored outside GET_A; input_a_ack stays 0 and no operand is captured.
REQ-026 output_z_ack is ignored while output_z_stb = 0.
REQ-027 Back-to-back throughput: the minimum spacing between captures is 3 cycles (normal operand, ack held high).
REQ-028 output_e arithmetic is 10-bit signed and never wraps; the minimum reached is -149.

Reset
REQ-029 While rst = 1 at an edge, regardless of state:
- state goes to GET_A.
- input_a_ack, output_z_stb, output_special go to 0.
- output_m, output_e, output_special_z go to 0.
REQ-030 On the first edge with rst = 0, input_a_ack goes to 1.
REQ-031 Reset mid-operation (UNPACK, NORMALISE or PUT_Z) discards the operand; no output_z_stb pulse follows.

Verification
REQ-032 Normal operand: input_a = 0x40800000 (4.0), ack held high -> output_m = 0x800000, output_e = +2, output_special = 0, output_z_stb high after edge n+1.
REQ-033 Denormal operand: input_a = 0x00000001 -> output_m = 0x800000, output_e = -149, output_z_stb high after edge n+25; input_a = 0x00400000 -> output_m = 0x800000, output_e = -127, output_z_stb high after edge n+3.
REQ-034 Special operands, each with output_special = 1:
- 0x7F800000 -> z = 0x7F800000.
- 0xFF800000 -> z = 0x7FC00000.
- 0x7FC00001 -> z = 0x7FC00000.
- 0x80000000 -> z = 0x80000000.
- 0xBF800000 -> z = 0x7FC00000.
REQ-035 Backpressure: hold output_z_ack = 0 for 10 cycles, with input_a_stb toggling throughout -> outputs stable, input_a_ack = 0, no capture; ack = 1 -> output_z_stb = 0 and input_a_ack = 1 on the same edge.
REQ-036 Reset mid-operation: assert rst in NORMALISE with input_a = 0x00000001 -> all outputs 0 the next cycle, input_a_ack = 1 one edge after rst is released, no stale output_z_stb.

Source files
------------

// File: rtl/sqrt_unpack.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_unpack
// Description : Binary32 operand unpack/normalise front end for a square-root
//               core; flags operands whose root is known without computation.
// Revision    : 1.0 - initial release
// ============================================================================
module sqrt_unpack (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [23:0] output_m,
    output logic [9:0]  output_e,
    output logic        output_special,
    output logic [31:0] output_special_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    typedef enum logic [1:0] {
        GET_A     = 2'd0,
        UNPACK    = 2'd1,
        NORMALISE = 2'd2,
        PUT_Z     = 2'd3
    } state_t;

    localparam logic [31:0] C_QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] C_POS_INF  = 32'h7F80_0000;
    localparam logic [9:0]  C_BIAS     = 10'd127;
    localparam logic [9:0]  C_DENORM_E = 10'(-126);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_a, w_a_nxt;
    logic        r_a_ack, w_a_ack_nxt;
    logic [23:0] r_m, w_m_nxt;
    logic [9:0]  r_e, w_e_nxt;
    logic        r_special, w_special_nxt;
    logic [31:0] r_z, w_z_nxt;
    logic        r_stb, w_stb_nxt;

    logic        w_sign;
    logic [7:0]  w_exp;
    logic [22:0] w_frac;

    assign w_sign = r_a[31];
    assign w_exp  = r_a[30:23];
    assign w_frac = r_a[22:0];

    always_comb begin
        w_state_nxt   = r_state;
        w_a_nxt       = r_a;
        w_a_ack_nxt   = r_a_ack;
        w_m_nxt       = r_m;
        w_e_nxt       = r_e;
        w_special_nxt = r_special;
        w_z_nxt       = r_z;
        w_stb_nxt     = r_stb;

        case (r_state)
            GET_A: begin
                // Ack rises one edge after reset release, then waits for a strobe.
                if (!r_a_ack) begin
                    w_a_ack_nxt = 1'b1;
                end else if (input_a_stb) begin
                    w_a_nxt     = input_a;
                    w_a_ack_nxt = 1'b0;
                    w_state_nxt = UNPACK;
                end
            end
            UNPACK: begin
                w_state_nxt   = PUT_Z;
                w_stb_nxt     = 1'b1;
                w_special_nxt = 1'b1;
                w_m_nxt       = 24'd0;
                w_e_nxt       = 10'd0;
                if (w_exp == 8'hFF && w_frac != 23'd0) begin
                    w_z_nxt = C_QNAN;
                end else if (w_exp == 8'hFF && !w_sign) begin
                    w_z_nxt = C_POS_INF;
                end else if (w_exp == 8'hFF) begin
                    w_z_nxt = C_QNAN;
                end else if (w_exp == 8'd0 && w_frac == 23'd0) begin
                    w_z_nxt = {w_sign, 31'd0};
                end else if (w_sign) begin
                    w_z_nxt = C_QNAN;
                end else if (w_exp == 8'd0) begin
                    w_special_nxt = 1'b0;
                    w_z_nxt       = 32'd0;
                    w_m_nxt       = {1'b0, w_frac};
                    w_e_nxt       = C_DENORM_E;
                    w_stb_nxt     = 1'b0;
                    w_state_nxt   = NORMALISE;
                end else begin
                    w_special_nxt = 1'b0;
                    w_z_nxt       = 32'd0;
                    w_m_nxt       = {1'b1, w_frac};
                    w_e_nxt       = {2'b00, w_exp} - C_BIAS;
                end
            end
            NORMALISE: begin
                if (r_m[23]) begin
                    w_state_nxt = PUT_Z;
                    w_stb_nxt   = 1'b1;
                end else begin
                    w_m_nxt = r_m << 1;
                    w_e_nxt = r_e - 10'd1;
                end
            end
            PUT_Z: begin
                if (output_z_ack) begin
                    w_stb_nxt   = 1'b0;
                    w_a_ack_nxt = 1'b1;
                    w_state_nxt = GET_A;
                end
            end
            default: w_state_nxt = GET_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= GET_A;
            r_a       <= 32'd0;
            r_a_ack   <= 1'b0;
            r_m       <= 24'd0;
            r_e       <= 10'd0;
            r_special <= 1'b0;
            r_z       <= 32'd0;
            r_stb     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_a       <= w_a_nxt;
            r_a_ack   <= w_a_ack_nxt;
            r_m       <= w_m_nxt;
            r_e       <= w_e_nxt;
            r_special <= w_special_nxt;
            r_z       <= w_z_nxt;
            r_stb     <= w_stb_nxt;
        end
    end

    assign input_a_ack      = r_a_ack;
    assign output_m         = r_m;
    assign output_e         = r_e;
    assign output_special   = r_special;
    assign output_special_z = r_z;
    assign output_z_stb     = r_stb;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_unpack.sv
`default_nettype none
// ============================================================================
// Module      : tb_sqrt_unpack
// Description : Directed self-checking bench for sqrt_unpack against a
//               value-level binary32 classification model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sqrt_unpack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] input_a = 32'd0;
    logic        input_a_stb = 1'b0;
    logic        input_a_ack;
    logic [23:0] output_m;
    logic [9:0]  output_e;
    logic        output_special;
    logic [31:0] output_special_z;
    logic        output_z_stb;
    logic        output_z_ack = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit          pending = 1'b0;
    logic        exp_sp;
    logic [31:0] exp_z;
    logic [23:0] exp_m;
    int          exp_e;
    int          exp_lat;

    sqrt_unpack dut (
        .clk              (clk),
        .rst              (rst),
        .input_a          (input_a),
        .input_a_stb      (input_a_stb),
        .input_a_ack      (input_a_ack),
        .output_m         (output_m),
        .output_e         (output_e),
        .output_special   (output_special),
        .output_special_z (output_special_z),
        .output_z_stb     (output_z_stb),
        .output_z_ack     (output_z_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Value-level model: classify the operand, then express a finite positive
    // value as 1.f * 2^e, with latency derived from how far a denormal is shifted.
    function automatic void model(input logic [31:0] a, output logic sp, output logic [31:0] z,
                                  output logic [23:0] m, output int e, output int lat);
        bit s;
        int ex, fr, p;
        bit is_nan, is_inf, is_zero;
        s       = a[31];
        ex      = int'(a[30:23]);
        fr      = int'(a[22:0]);
        is_nan  = (ex == 255) && (fr != 0);
        is_inf  = (ex == 255) && (fr == 0);
        is_zero = (ex == 0) && (fr == 0);
        sp = 1'b0; z = 32'd0; m = 24'd0; e = 0; lat = 1;
        if (is_nan || (s && !is_zero)) begin
            sp = 1'b1; z = 32'h7FC00000;
        end else if (is_inf) begin
            sp = 1'b1; z = 32'h7F800000;
        end else if (is_zero) begin
            sp = 1'b1; z = {s, 31'd0};
        end else if (ex == 0) begin
            p   = $clog2(fr + 1) - 1;
            m   = 24'(fr << (23 - p));
            e   = p - 149;
            lat = 25 - p;
        end else begin
            m = 24'(fr + (1 << 23));
            e = ex - 127;
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && output_z_stb) begin
            check("stb_has_capture", 32'(pending), 32'd1);
            if (pending) begin
                check("output_m", 32'(output_m), 32'(exp_m));
                check("output_e", 32'(signed'(output_e)), exp_e);
                check("output_special", 32'(output_special), 32'(exp_sp));
                check("output_special_z", output_special_z, exp_z);
                check("ack_low_in_put_z", 32'(input_a_ack), 32'd0);
            end
        end
    end

    task automatic wait_ack(output bit ok);
        int n = 0;
        while (!input_a_ack && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = input_a_ack;
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL ack_timeout: got 0 expected 1");
        end
    endtask

    task automatic set_expect(input logic [31:0] a);
        logic        sp;
        logic [31:0] z;
        logic [23:0] m;
        int          e, lat;
        model(a, sp, z, m, e, lat);
        exp_sp = sp; exp_z = z; exp_m = m; exp_e = e; exp_lat = lat;
    endtask

    task automatic transact(input logic [31:0] a, input int hold, input bit toggle);
        bit ok;
        int cap, n;
        @(negedge clk);
        input_a = a;
        input_a_stb = 1'b1;
        wait_ack(ok);
        if (!ok) return;
        set_expect(a);
        pending = 1'b1;
        @(posedge clk); #1;
        cap = cyc;
        input_a_stb = 1'b0;
        @(negedge clk);
        n = 0;
        while (!output_z_stb && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(cyc - cap), 32'(exp_lat));
        repeat (hold) begin
            if (toggle) begin
                input_a_stb = ~input_a_stb;
                input_a = $urandom;
            end
            @(negedge clk);
        end
        input_a_stb = 1'b0;
        output_z_ack = 1'b1;
        @(posedge clk); #1;
        check("stb_drop_on_ack", 32'(output_z_stb), 32'd0);
        check("ack_rise_on_ack", 32'(input_a_ack), 32'd1);
        pending = 1'b0;
        output_z_ack = 1'b0;
    endtask

    initial begin : stim
        logic [31:0] vec [12];
        logic        sp;
        logic [31:0] z;
        logic [23:0] m;
        int          e, lat, c1, c2;
        bit          ok;

        // Model pins against hand-computed values.
        model(32'h40800000, sp, z, m, e, lat);
        check("pin_4p0_m", 32'(m), 32'h800000);
        check("pin_4p0_e", 32'(e), 32'd2);
        model(32'h00000001, sp, z, m, e, lat);
        check("pin_min_den_e", 32'(e), 32'(-149));
        check("pin_min_den_lat", 32'(lat), 32'd25);
        model(32'h00400000, sp, z, m, e, lat);
        check("pin_den22_e", 32'(e), 32'(-127));
        check("pin_den22_lat", 32'(lat), 32'd3);
        model(32'hFF800000, sp, z, m, e, lat);
        check("pin_neg_inf_z", z, 32'h7FC00000);
        model(32'h80000000, sp, z, m, e, lat);
        check("pin_neg_zero_z", z, 32'h80000000);

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(input_a_ack), 32'd0);
        check("rst_stb", 32'(output_z_stb), 32'd0);
        check("rst_m", 32'(output_m), 32'd0);
        check("rst_e", 32'(output_e), 32'd0);
        check("rst_special", 32'(output_special), 32'd0);
        check("rst_z", output_special_z, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ack_after_release", 32'(input_a_ack), 32'd1);

        vec = '{32'h40800000, 32'h3F800000, 32'h7F7FFFFF, 32'h00800000,
                32'h00000001, 32'h00400000, 32'h00012345, 32'h7F800000,
                32'hFF800000, 32'h7FC00001, 32'h80000000, 32'hBF800000};
        foreach (vec[i]) transact(vec[i], 0, 1'b0);
        transact(32'h00000000, 1, 1'b0);
        transact(32'h7F800001, 2, 1'b0);

        // Backpressure with the input strobe toggling.
        transact(32'h41200000, 10, 1'b1);
        transact(32'h00000100, 10, 1'b1);

        // Back-to-back throughput with ack held high.
        @(negedge clk);
        output_z_ack = 1'b1;
        input_a = 32'h3F800000;
        input_a_stb = 1'b1;
        set_expect(32'h3F800000);
        pending = 1'b1;
        wait_ack(ok);
        @(posedge clk); #1 c1 = cyc;
        @(negedge clk);
        wait_ack(ok);
        @(posedge clk); #1 c2 = cyc;
        input_a_stb = 1'b0;
        check("throughput_spacing", 32'(c2 - c1), 32'd3);
        repeat (3) @(negedge clk);
        pending = 1'b0;
        output_z_ack = 1'b0;

        // Reset while normalising a denormal.
        @(negedge clk);
        input_a = 32'h00000001;
        input_a_stb = 1'b1;
        wait_ack(ok);
        set_expect(32'h00000001);
        pending = 1'b1;
        @(posedge clk); #1;
        input_a_stb = 1'b0;
        repeat (5) @(negedge clk);
        pending = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_ack", 32'(input_a_ack), 32'd0);
        check("midrst_stb", 32'(output_z_stb), 32'd0);
        check("midrst_m", 32'(output_m), 32'd0);
        check("midrst_e", 32'(output_e), 32'd0);
        check("midrst_special", 32'(output_special), 32'd0);
        check("midrst_z", output_special_z, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_ack_release", 32'(input_a_ack), 32'd1);
        repeat (30) @(negedge clk);
        check("midrst_no_stale_stb", 32'(output_z_stb), 32'd0);

        // Block still operates after the mid-operation reset.
        transact(32'h40800000, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
